// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply/divide unit with HI/LO result registers.
// Signed ops run on magnitudes; the sign is fixed up in FINISH.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_dbz_pend;
    logic [WIDTH-1:0]   r_m;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_neg_quo;
    logic [WIDTH-1:0]   w_neg_rem;
    logic [2*WIDTH-1:0] w_neg_acc;
    logic               w_neg_res;

    assign w_sa    = op[0] & operand_a[WIDTH-1];
    assign w_sb    = op[0] & operand_b[WIDTH-1];
    assign w_mag_a = w_sa ? (~operand_a + 1'b1) : operand_a;
    assign w_mag_b = w_sb ? (~operand_b + 1'b1) : operand_b;

    // Multiply adds into the upper half; divide trial-subtracts from it.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
    assign w_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff  = w_shift - {1'b0, r_m};

    assign w_quo     = r_acc[WIDTH-1:0];
    assign w_rem     = r_acc[2*WIDTH-1:WIDTH];
    assign w_neg_quo = ~w_quo + 1'b1;
    assign w_neg_rem = ~w_rem + 1'b1;
    assign w_neg_acc = ~r_acc + 1'b1;
    assign w_neg_res = r_sign_a ^ r_sign_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_RUN;
            S_RUN:    if (r_cnt == CW'(WIDTH - 1)) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_m        <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div   <= op[1];
                        r_sign_a   <= w_sa;
                        r_sign_b   <= w_sb;
                        r_dbz_pend <= op[1] && (operand_b == '0);
                        r_cnt      <= '0;
                        if (op[1]) begin
                            r_m   <= w_mag_b;
                            r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                        end else begin
                            r_m   <= w_mag_a;
                            r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        if (!w_diff[WIDTH])
                            r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                        else
                            r_acc <= {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                    end else begin
                        if (r_acc[0])
                            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                        else
                            r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
                    end
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    r_dbz  <= r_dbz_pend;
                    if (r_is_div) begin
                        // A zero divisor leaves |a| in the remainder, so hi needs no override.
                        r_hi <= r_sign_a ? w_neg_rem : w_rem;
                        if (r_dbz_pend)
                            r_lo <= '1;
                        else
                            r_lo <= w_neg_res ? w_neg_quo : w_quo;
                    end else begin
                        {r_hi, r_lo} <= w_neg_res ? w_neg_acc : r_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
